// File: rtl/vend_pkg.sv
// Shared types and fixed pricing for the vending-machine transaction core.
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPENSE = 2'd1,
        ST_CHANGE   = 2'd2
    } state_t;

    localparam int NUM_ITEMS   = 4;
    localparam int COIN_100    = 100;
    localparam int COIN_500    = 500;
    localparam int CHANGE_UNIT = 100;

    localparam int PRICE [NUM_ITEMS] = '{300, 500, 700, 1000};

    function automatic int price_of(input logic [1:0] idx);
        return PRICE[idx];
    endfunction

endpackage

// File: rtl/vend_stock_counter.sv
// Per-item stock down-counter: loads STOCK_INIT on reset, saturates at zero.
module vend_stock_counter #(
    parameter int STOCK_W    = 4,
    parameter int STOCK_INIT = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic dec,
    output logic zero
);

    logic [STOCK_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (dec && (count_q != '0)) begin
            count_d = count_q - STOCK_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= STOCK_W'(STOCK_INIT);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending-machine transaction core: coin credit, buy validation, timed dispense, change return.
// Optional idle auto-return of credit is enabled by defining VEND_AUTO_RETURN_EN.
module vend_controller
    import vend_pkg::*;
#(
    parameter int CREDIT_W        = 11,
    parameter int MAX_CREDIT      = 2000,
    parameter int STOCK_W         = 4,
    parameter int STOCK_INIT      = 5,
    parameter int DISPENSE_CYCLES = 4
`ifdef VEND_AUTO_RETURN_EN
    ,
    parameter int IDLE_TIMEOUT    = 1000
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          buy_pulse,
    input  logic [1:0]          coin_pulse,
    input  logic                return_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic [3:0]          dispense,
    output logic [3:0]          sold_out,
    output logic                change_100,
    output logic                coin_reject,
    output logic                err,
    output logic                busy
);

    localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;
    localparam int SUM_W = CREDIT_W + 1;

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [3:0]          dispense_q, dispense_d;
    logic [CNT_W-1:0]    disp_cnt_q, disp_cnt_d;
    logic                phase_q, phase_d;
    logic                change_q, change_d;
    logic                coin_reject_q, coin_reject_d;
    logic                err_q, err_d;

    logic [3:0]          stock_dec;
    logic [3:0]          stock_zero;
    logic                buy_one_hot;
    logic [1:0]          buy_idx;
    logic [CREDIT_W-1:0] price;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] credit_add;
    logic [CREDIT_W-1:0] credit_sub;
    logic [SUM_W-1:0]    coin_sum;
    logic                coin_ok;
    logic                buy_ok;
    logic                ret_ok;
    logic                change_fire;
    logic                auto_ret;

`ifdef VEND_AUTO_RETURN_EN
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
    logic              idle_cond;

    always_comb begin
        idle_cond  = (state_q == ST_IDLE) && (credit_q != '0) && (buy_pulse == 4'd0)
                     && (coin_pulse == 2'd0) && !return_pulse;
        auto_ret   = idle_cond && (idle_cnt_q == IDLE_W'(IDLE_TIMEOUT - 1));
        idle_cnt_d = (idle_cond && !auto_ret) ? idle_cnt_q + IDLE_W'(1) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign auto_ret = 1'b0;
`endif

    // Request decode; buys are judged against the credit before any same-cycle coin.
    always_comb begin
        case (buy_pulse)
            4'b0010: buy_idx = 2'd1;
            4'b0100: buy_idx = 2'd2;
            4'b1000: buy_idx = 2'd3;
            default: buy_idx = 2'd0;
        endcase
        buy_one_hot = (buy_pulse != 4'd0) && ((buy_pulse & (buy_pulse - 4'd1)) == 4'd0);
        price       = CREDIT_W'(price_of(buy_idx));
        coin_val    = coin_pulse[1] ? CREDIT_W'(COIN_500) : CREDIT_W'(COIN_100);
        coin_sum    = {1'b0, credit_q} + {1'b0, coin_val};
        coin_ok     = ((coin_pulse == 2'b01) || (coin_pulse == 2'b10)) && (state_q != ST_CHANGE)
                      && (coin_sum <= SUM_W'(MAX_CREDIT));
        buy_ok      = (state_q == ST_IDLE) && buy_one_hot && !stock_zero[buy_idx]
                      && (credit_q >= price);
        ret_ok      = (state_q == ST_IDLE) && (return_pulse || auto_ret) && (credit_q != '0)
                      && !buy_ok;
        change_fire = ret_ok || ((state_q == ST_CHANGE) && phase_q);
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d       = state_q;
        dispense_d    = dispense_q;
        disp_cnt_d    = disp_cnt_q;
        phase_d       = phase_q;
        credit_add    = coin_ok ? coin_val : '0;
        credit_sub    = buy_ok ? price : (change_fire ? CREDIT_W'(CHANGE_UNIT) : '0);
        credit_d      = credit_q + credit_add - credit_sub;
        stock_dec     = buy_ok ? buy_pulse : 4'd0;
        change_d      = change_fire;
        coin_reject_d = (coin_pulse != 2'd0) && !coin_ok;
        err_d         = (buy_pulse != 4'd0) && !buy_ok;

        case (state_q)
            ST_IDLE: begin
                if (buy_ok) begin
                    state_d    = ST_DISPENSE;
                    dispense_d = buy_pulse;
                    disp_cnt_d = CNT_W'(DISPENSE_CYCLES - 1);
                end else if (ret_ok) begin
                    phase_d = 1'b0;
                    if (credit_d != '0) begin
                        state_d = ST_CHANGE;
                    end
                end
            end
            ST_DISPENSE: begin
                if (disp_cnt_q == '0) begin
                    state_d    = ST_IDLE;
                    dispense_d = 4'd0;
                end else begin
                    disp_cnt_d = disp_cnt_q - CNT_W'(1);
                end
            end
            ST_CHANGE: begin
                // Pulses land on alternate cycles; the phase bit marks the pulse cycle.
                phase_d = !phase_q;
                if (phase_q && (credit_d == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            dispense_q    <= 4'd0;
            disp_cnt_q    <= '0;
            phase_q       <= 1'b0;
            change_q      <= 1'b0;
            coin_reject_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            dispense_q    <= dispense_d;
            disp_cnt_q    <= disp_cnt_d;
            phase_q       <= phase_d;
            change_q      <= change_d;
            coin_reject_q <= coin_reject_d;
            err_q         <= err_d;
        end
    end

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_stock
        vend_stock_counter #(
            .STOCK_W    (STOCK_W),
            .STOCK_INIT (STOCK_INIT)
        ) u_stock (
            .clk   (clk),
            .reset (reset),
            .dec   (stock_dec[i]),
            .zero  (stock_zero[i])
        );
    end

    assign credit      = credit_q;
    assign dispense    = dispense_q;
    assign sold_out    = stock_zero;
    assign change_100  = change_q;
    assign coin_reject = coin_reject_q;
    assign err         = err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: behavioural money/stock model plus directed and random stimulus.
module tb_vend_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  buy_pulse = 4'd0;
    logic [1:0]  coin_pulse = 2'd0;
    logic        return_pulse = 1'b0;
    logic [10:0] credit;
    logic [3:0]  dispense;
    logic [3:0]  sold_out;
    logic        change_100;
    logic        coin_reject;
    logic        err;
    logic        busy;

    int n_vec = 0;
    int n_bad = 0;

    vend_controller dut (
        .clk          (clk),
        .reset        (reset),
        .buy_pulse    (buy_pulse),
        .coin_pulse   (coin_pulse),
        .return_pulse (return_pulse),
        .credit       (credit),
        .dispense     (dispense),
        .sold_out     (sold_out),
        .change_100   (change_100),
        .coin_reject  (coin_reject),
        .err          (err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Model: money in won, stock per item, dispense time left, change progress.
    int price_tab [4] = '{300, 500, 700, 1000};
    int m_credit;
    int m_stock [4];
    int m_disp;
    int m_disp_left;
    bit m_in_change;
    int m_chg_t;
    int m_idle_cnt;
    bit exp_chg, exp_rej, exp_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_credit = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 5;
        m_disp = 0;
        m_disp_left = 0;
        m_in_change = 0;
        m_chg_t = 0;
        m_idle_cnt = 0;
        exp_chg = 0;
        exp_rej = 0;
        exp_err = 0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic [1:0] c, input logic r);
        bit idle, coin_ok, buy_ok, ret_ok, auto_ret;
        int cv, nc, idx;
        idle = (m_disp_left == 0) && !m_in_change;
        cv = (c == 2'b01) ? 100 : (c == 2'b10) ? 500 : 0;
        coin_ok = (cv != 0) && !m_in_change && (m_credit + cv <= 2000);
        exp_rej = (c != 2'b00) && !coin_ok;
        idx = 0;
        for (int i = 0; i < 4; i++) if (b[i]) idx = i;
        buy_ok = idle && ($countones(b) == 1) && (m_stock[idx] > 0) && (m_credit >= price_tab[idx]);
        exp_err = (b != 4'd0) && !buy_ok;
        auto_ret = 0;
`ifdef VEND_AUTO_RETURN_EN
        if (idle && m_credit > 0 && b == 4'd0 && c == 2'd0 && !r) begin
            m_idle_cnt++;
            if (m_idle_cnt == 1000) begin
                auto_ret = 1;
                m_idle_cnt = 0;
            end
        end else begin
            m_idle_cnt = 0;
        end
`endif
        ret_ok = idle && (r || auto_ret) && (m_credit > 0) && !buy_ok;
        nc = m_credit + (coin_ok ? cv : 0) - (buy_ok ? price_tab[idx] : 0);
        exp_chg = 0;
        if (ret_ok) begin
            exp_chg = 1;
            nc -= 100;
            m_in_change = (nc > 0);
            m_chg_t = 0;
        end else if (m_in_change) begin
            m_chg_t++;
            if (m_chg_t % 2 == 0) begin
                exp_chg = 1;
                nc -= 100;
                if (nc == 0) m_in_change = 0;
            end
        end
        if (buy_ok) begin
            m_stock[idx]--;
            m_disp = 1 << idx;
            m_disp_left = 4;
        end else if (m_disp_left > 0) begin
            m_disp_left--;
            if (m_disp_left == 0) m_disp = 0;
        end
        m_credit = nc;
    endtask

    task automatic compare_all();
        logic [3:0] so;
        for (int i = 0; i < 4; i++) so[i] = (m_stock[i] == 0);
        check("credit", credit, m_credit);
        check("dispense", dispense, m_disp);
        check("sold_out", sold_out, so);
        check("change_100", change_100, exp_chg);
        check("coin_reject", coin_reject, exp_rej);
        check("err", err, exp_err);
        check("busy", busy, (m_disp_left > 0) || m_in_change);
    endtask

    task automatic tick(input logic [3:0] b, input logic [1:0] c, input logic r);
        buy_pulse = b;
        coin_pulse = c;
        return_pulse = r;
        @(posedge clk);
        model_step(b, c, r);
        #1;
        compare_all();
        buy_pulse = 4'd0;
        coin_pulse = 2'd0;
        return_pulse = 1'b0;
    endtask

    // Asynchronous: outputs must clear before any clock edge arrives.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_busy_lit", busy, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int pulses;
        logic [3:0] rb;
        logic [1:0] rc;
        logic rr;

        #2;
        do_reset();
        check("rst_credit_lit", credit, 0);

        // 1: coin 500, buy item 0
        tick(4'd0, 2'b10, 1'b0);
        tick(4'b0001, 2'b00, 1'b0);
        check("t1_credit_lit", credit, 200);
        check("t1_disp_lit", dispense, 4'b0001);
        for (int i = 0; i < 3; i++) begin
            tick(4'd0, 2'b00, 1'b0);
            check("t1_disp_hold_lit", dispense, 4'b0001);
        end
        tick(4'd0, 2'b00, 1'b0);
        check("t1_disp_end_lit", dispense, 4'b0000);

        // 2: insufficient credit
        tick(4'b0010, 2'b00, 1'b0);
        check("t2_err_lit", err, 1);
        check("t2_credit_lit", credit, 200);

        // 3: ceiling
        for (int i = 0; i < 3; i++) tick(4'd0, 2'b10, 1'b0);
        for (int i = 0; i < 2; i++) tick(4'd0, 2'b01, 1'b0);
        check("t3_credit1900_lit", credit, 1900);
        tick(4'd0, 2'b10, 1'b0);
        check("t3_reject_lit", coin_reject, 1);
        check("t3_hold_lit", credit, 1900);
        tick(4'd0, 2'b01, 1'b0);
        check("t3_credit2000_lit", credit, 2000);
        tick(4'd0, 2'b11, 1'b0);
        check("t3_both_reject_lit", coin_reject, 1);

        // 4: drain then 300-won change sequence
        tick(4'd0, 2'b00, 1'b1);
        k = 0;
        while (busy && k < 100) begin
            tick(4'd0, 2'b00, 1'b0);
            k++;
        end
        check("t4_drain_done", busy, 0);
        check("t4_drain_credit_lit", credit, 0);
        for (int i = 0; i < 3; i++) tick(4'd0, 2'b01, 1'b0);
        tick(4'd0, 2'b00, 1'b1);
        check("t4_p1_lit", change_100, 1);
        check("t4_c1_lit", credit, 200);
        tick(4'd0, 2'b00, 1'b0);
        check("t4_gap1_lit", change_100, 0);
        tick(4'd0, 2'b00, 1'b0);
        check("t4_p3_lit", change_100, 1);
        tick(4'd0, 2'b00, 1'b0);
        tick(4'd0, 2'b00, 1'b0);
        check("t4_p5_lit", change_100, 1);
        check("t4_c5_lit", credit, 0);
        check("t4_busy5_lit", busy, 0);

        // 5: sell out item 0
        do_reset();
        for (int n = 1; n <= 6; n++) begin
            tick(4'd0, 2'b10, 1'b0);
            tick(4'b0001, 2'b00, 1'b0);
            if (n == 6) check("t5_err6_lit", err, 1);
            for (int i = 0; i < 4; i++) tick(4'd0, 2'b00, 1'b0);
            if (n == 4) check("t5_so4_lit", sold_out[0], 0);
            if (n == 5) check("t5_so5_lit", sold_out[0], 1);
        end

        // 6: multi-hot buy, then reset mid-dispense
        do_reset();
        tick(4'd0, 2'b10, 1'b0);
        tick(4'b0011, 2'b00, 1'b0);
        check("t6_err_lit", err, 1);
        check("t6_credit_lit", credit, 500);
        check("t6_disp_lit", dispense, 0);
        tick(4'b0010, 2'b00, 1'b0);
        tick(4'd0, 2'b00, 1'b0);
        do_reset();
        check("t6_rst_disp_lit", dispense, 0);

`ifdef VEND_AUTO_RETURN_EN
        tick(4'd0, 2'b01, 1'b0);
        pulses = 0;
        for (int i = 0; i < 1010; i++) begin
            tick(4'd0, 2'b00, 1'b0);
            if (change_100) pulses++;
        end
        check("auto_pulses_lit", pulses, 1);
        check("auto_credit_lit", credit, 0);
        do_reset();
`endif

        // Random traffic, periodic reset to refill stock
        for (int n = 0; n < 3000; n++) begin
            if (n % 250 == 249) do_reset();
            case ($urandom_range(0, 19))
                0:       rb = 4'($urandom_range(0, 15));
                1, 2, 3: rb = 4'(1 << $urandom_range(0, 3));
                default: rb = 4'd0;
            endcase
            case ($urandom_range(0, 9))
                0, 1, 2: rc = 2'b01;
                3:       rc = 2'b10;
                4:       rc = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b00;
                default: rc = 2'b00;
            endcase
            rr = ($urandom_range(0, 29) == 0);
            tick(rb, rc, rr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
